// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - CPU request and RAM port bundle for mem_access_ctrl
interface mem_access_ctrl_if #(
    parameter int WORD_ADDR_W = 5
);
    logic                   req;
    logic                   we;
    logic [1:0]             size;
    logic                   sign_ext;
    logic [WORD_ADDR_W+1:0] addr;
    logic [31:0]            wdata;
    logic                   ready;
    logic                   done;
    logic                   err;
    logic [31:0]            rdata;
    logic                   mem_W_En;
    logic [WORD_ADDR_W-1:0] mem_Addr;
    logic [31:0]            mem_D_In;
    logic [31:0]            mem_D_Out;

    // master is the CPU plus RAM side; slave is the controller
    modport master (
        output req, we, size, sign_ext, addr, wdata, mem_D_Out,
        input  ready, done, err, rdata, mem_W_En, mem_Addr, mem_D_In
    );

    modport slave (
        input  req, we, size, sign_ext, addr, wdata, mem_D_Out,
        output ready, done, err, rdata, mem_W_En, mem_Addr, mem_D_In
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - byte/half/word load-store controller for a single-port word RAM
module mem_access_ctrl #(
    parameter int WORD_ADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    mem_access_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, RD, RDV, WR} state_t;

    state_t                 state_q, state_d;
    logic                   we_q, we_d;
    logic [1:0]             size_q, size_d;
    logic                   sext_q, sext_d;
    logic [1:0]             addr_lo_q, addr_lo_d;
    logic [15:0]            wdata_lo_q, wdata_lo_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic [31:0]            rdata_q, rdata_d;
    logic [WORD_ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]            mem_d_in_q, mem_d_in_d;

    logic        accept;
    logic        bad;
    logic        is_word_store;
    logic [31:0] load_shift;
    logic [31:0] load_val;
    logic [31:0] lane_mask;
    logic [31:0] lane_data;
    logic [31:0] merged;

    assign accept        = bus.req && (state_q == IDLE);
    assign bad           = (bus.size == 2'b11)
                        || (bus.size == 2'b10 && bus.addr[1:0] != 2'b00)
                        || (bus.size == 2'b01 && bus.addr[0]);
    assign is_word_store = bus.we && (bus.size == 2'b10);

    always_comb begin
        load_shift = 32'h0;
        load_val   = bus.mem_D_Out;
        lane_mask  = 32'hFFFF_FFFF;
        lane_data  = 32'h0;
        case (size_q)
            2'b00: begin
                load_shift = bus.mem_D_Out >> {addr_lo_q, 3'b000};
                load_val   = {{24{sext_q & load_shift[7]}}, load_shift[7:0]};
                lane_mask  = 32'h0000_00FF << {addr_lo_q, 3'b000};
                lane_data  = {24'h0, wdata_lo_q[7:0]} << {addr_lo_q, 3'b000};
            end
            2'b01: begin
                load_shift = bus.mem_D_Out >> {addr_lo_q[1], 4'b0000};
                load_val   = {{16{sext_q & load_shift[15]}}, load_shift[15:0]};
                lane_mask  = 32'h0000_FFFF << {addr_lo_q[1], 4'b0000};
                lane_data  = {16'h0, wdata_lo_q} << {addr_lo_q[1], 4'b0000};
            end
            default: ;
        endcase
        merged = (bus.mem_D_Out & ~lane_mask) | (lane_data & lane_mask);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept && !bad) state_d = is_word_store ? WR : RD;
            RD:   state_d = RDV;
            RDV:  state_d = we_q ? WR : IDLE;
            WR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.ready    = (state_q == IDLE);
        bus.mem_W_En = (state_q == WR);
    end

    // Datapath next-state: latched request fields, RAM drive and response
    always_comb begin
        we_d       = we_q;
        size_d     = size_q;
        sext_d     = sext_q;
        addr_lo_d  = addr_lo_q;
        wdata_lo_d = wdata_lo_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        rdata_d    = rdata_q;
        mem_addr_d = mem_addr_q;
        mem_d_in_d = mem_d_in_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    we_d       = bus.we;
                    size_d     = bus.size;
                    sext_d     = bus.sign_ext;
                    addr_lo_d  = bus.addr[1:0];
                    wdata_lo_d = bus.wdata[15:0];
                    if (bad) begin
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        rdata_d = 32'h0;
                    end else begin
                        mem_addr_d = bus.addr[WORD_ADDR_W+1:2];
                        if (is_word_store) mem_d_in_d = bus.wdata;
                    end
                end
            end
            RDV: begin
                if (we_q) begin
                    mem_d_in_d = merged;
                end else begin
                    rdata_d = load_val;
                    done_d  = 1'b1;
                end
            end
            WR: begin
                rdata_d = 32'h0;
                done_d  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q       <= 1'b0;
            size_q     <= 2'b00;
            sext_q     <= 1'b0;
            addr_lo_q  <= 2'b00;
            wdata_lo_q <= 16'h0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= 32'h0;
            mem_addr_q <= '0;
            mem_d_in_q <= 32'h0;
        end else begin
            we_q       <= we_d;
            size_q     <= size_d;
            sext_q     <= sext_d;
            addr_lo_q  <= addr_lo_d;
            wdata_lo_q <= wdata_lo_d;
            done_q     <= done_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            mem_addr_q <= mem_addr_d;
            mem_d_in_q <= mem_d_in_d;
        end
    end

    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.rdata    = rdata_q;
    assign bus.mem_Addr = mem_addr_q;
    assign bus.mem_D_In = mem_d_in_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - scoreboard bench for mem_access_ctrl with a behavioural RAM
module tb_mem_access_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_access_ctrl_if #(.WORD_ADDR_W(5)) bus();
    mem_access_ctrl #(.WORD_ADDR_W(5)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [31:0] ram [32];
    always @(posedge clk) begin
        if (bus.mem_W_En) ram[bus.mem_Addr] <= bus.mem_D_In;
        else              bus.mem_D_Out     <= ram[bus.mem_Addr];
    end

    int cyc = 0;
    int wen_cnt = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (bus.mem_W_En) wen_cnt <= wen_cnt + 1;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          due;
        string       name;
    } exp_t;
    exp_t q[$];

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus.done === 1'b1) begin
            if (q.size() == 0) begin
                check("unexpected_done", {31'h0, bus.done}, 32'h0);
            end else begin
                e = q.pop_front();
                check({e.name, "_err"},   {31'h0, bus.err}, {31'h0, e.err});
                check({e.name, "_rdata"}, bus.rdata, e.rdata);
                check({e.name, "_lat"},   cyc, e.due);
            end
        end
    end

    task automatic issue(input string name, input logic w, input logic [1:0] sz,
                         input logic sx, input logic [6:0] a, input logic [31:0] wd,
                         input logic e_err, input logic [31:0] e_rd, input int lat,
                         input logic push);
        int n = 0;
        int start;
        while (bus.ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (bus.ready !== 1'b1) check({name, "_ready_timeout"}, {31'h0, bus.ready}, 32'h1);
        bus.req      = 1'b1;
        bus.we       = w;
        bus.size     = sz;
        bus.sign_ext = sx;
        bus.addr     = a;
        bus.wdata    = wd;
        start        = cyc;
        @(posedge clk);
        if (push) q.push_back('{e_err, e_rd, start + 1 + lat, name});
        @(negedge clk);
        bus.req = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) check("drain_timeout", q.size(), 32'h0);
    endtask

    int w0;

    initial begin
        for (int i = 0; i < 32; i++) ram[i] <= 32'h1000_0000 + i;
        ram[5] <= 32'h8C01_0050;
        rst = 1'b1;
        bus.req = 1'b0; bus.we = 1'b0; bus.size = 2'b00; bus.sign_ext = 1'b0;
        bus.addr = '0; bus.wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", {31'h0, bus.ready},    32'h1);
        check("rst_done",  {31'h0, bus.done},     32'h0);
        check("rst_err",   {31'h0, bus.err},      32'h0);
        check("rst_rdata", bus.rdata,             32'h0);
        check("rst_wen",   {31'h0, bus.mem_W_En}, 32'h0);
        check("rst_maddr", {27'h0, bus.mem_Addr}, 32'h0);
        check("rst_mdin",  bus.mem_D_In,          32'h0);
        rst = 1'b0;
        @(negedge clk);

        issue("lw_14",  0, 2'b10, 0, 7'h14, 0, 0, 32'h8C01_0050, 2, 1);
        issue("lb_17",  0, 2'b00, 1, 7'h17, 0, 0, 32'hFFFF_FF8C, 2, 1);
        issue("lhu_16", 0, 2'b01, 0, 7'h16, 0, 0, 32'h0000_8C01, 2, 1);
        issue("lbu_16", 0, 2'b00, 0, 7'h16, 0, 0, 32'h0000_0001, 2, 1);
        issue("lh_14",  0, 2'b01, 1, 7'h14, 0, 0, 32'h0000_0050, 2, 1);
        drain();

        w0 = wen_cnt;
        issue("sb_15", 1, 2'b00, 0, 7'h15, 32'h0000_00AB, 0, 32'h0, 3, 1);
        drain();
        check("sb_15_ram",  ram[5], 32'h8C01_AB50);
        check("sb_15_wens", wen_cnt - w0, 32'h1);
        issue("lw_14b",  0, 2'b10, 0, 7'h14, 0, 0, 32'h8C01_AB50, 2, 1);
        issue("lh_14s",  0, 2'b01, 1, 7'h14, 0, 0, 32'hFFFF_AB50, 2, 1);
        issue("lh_16s",  0, 2'b01, 1, 7'h16, 0, 0, 32'hFFFF_8C01, 2, 1);

        issue("sh_1a",   1, 2'b01, 0, 7'h1A, 32'h0000_F00D, 0, 32'h0, 3, 1);
        issue("lhu_1a",  0, 2'b01, 0, 7'h1A, 0, 0, 32'h0000_F00D, 2, 1);
        issue("lh_1a",   0, 2'b01, 1, 7'h1A, 0, 0, 32'hFFFF_F00D, 2, 1);
        issue("sb_18",   1, 2'b00, 0, 7'h18, 32'hFFFF_FF77, 0, 32'h0, 3, 1);
        issue("lw_18",   0, 2'b10, 0, 7'h18, 0, 0, 32'hF00D_0077, 2, 1);
        drain();

        w0 = wen_cnt;
        issue("err_lw16", 0, 2'b10, 0, 7'h16, 0, 1, 32'h0, 0, 1);
        issue("err_sz11", 0, 2'b11, 0, 7'h14, 0, 1, 32'h0, 0, 1);
        issue("err_lh15", 0, 2'b01, 1, 7'h15, 0, 1, 32'h0, 0, 1);
        issue("err_sw19", 1, 2'b10, 0, 7'h19, 32'h1234_5678, 1, 32'h0, 0, 1);
        drain();
        check("err_wens", wen_cnt - w0, 32'h0);
        check("err_ram5", ram[5], 32'h8C01_AB50);

        w0 = wen_cnt;
        issue("sw_58", 1, 2'b10, 0, 7'h58, 32'hBEEF_0000, 0, 32'h0, 1, 1);
        issue("lw_58", 0, 2'b10, 0, 7'h58, 0, 0, 32'hBEEF_0000, 2, 1);
        issue("sb_14", 1, 2'b00, 0, 7'h14, 32'h0000_0011, 0, 32'h0, 3, 1);
        issue("lw_14c", 0, 2'b10, 0, 7'h14, 0, 0, 32'h8C01_AB11, 2, 1);
        drain();
        check("b2b_wens", wen_cnt - w0, 32'h2);
        check("sw_58_ram", ram[22], 32'hBEEF_0000);

        w0 = wen_cnt;
        issue("sh_1c_rst", 1, 2'b01, 0, 7'h1C, 32'h0000_5555, 0, 32'h0, 3, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rstmid_ready", {31'h0, bus.ready}, 32'h1);
        check("rstmid_done",  {31'h0, bus.done},  32'h0);
        repeat (6) @(negedge clk);
        check("rstmid_wens", wen_cnt - w0, 32'h0);
        check("rstmid_ram7", ram[7], 32'h1000_0007);

        w0 = wen_cnt;
        rst = 1'b1;
        bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'b10; bus.addr = 7'h1C;
        bus.wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.req = 1'b0;
        check("rstreq_ready", {31'h0, bus.ready},    32'h1);
        check("rstreq_maddr", {27'h0, bus.mem_Addr}, 32'h0);
        repeat (4) @(negedge clk);
        check("rstreq_wens", wen_cnt - w0, 32'h0);
        check("rstreq_ram7", ram[7], 32'h1000_0007);

        issue("lw_1c", 0, 2'b10, 0, 7'h1C, 0, 0, 32'h1000_0007, 2, 1);
        drain();
        check("queue_empty", q.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
